// File: rtl/key_tx_queue_pkg.sv
// Shared constants and Tx FSM state encoding for the keyboard/switch UART byte source.
package key_tx_queue_pkg;

    localparam logic [7:0] KB_BREAK = 8'hF0;
    localparam logic [7:0] KB_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/key_tx_queue_sync_fifo.sv
// Single-clock byte FIFO with occupancy count; head is readable combinationally so the
// transmitter can launch a byte in the cycle right after it was pushed.
module key_tx_queue_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push on full is still taken.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/key_tx_queue.sv
// Merges decoded key presses and debounced switch bytes into a FIFO and feeds the UART
// transmitter one byte per frame over a tx_start / tx_busy handshake.
module key_tx_queue
    import key_tx_queue_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int DEBOUNCE    = 1_000_000,
    parameter int REPEAT_EN   = 0,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   kb_flag_i,
    input  logic [15:0]            kb_keycode_i,
    input  logic [7:0]             kb_char_i,
    input  logic [7:0]             sw_data_i,
    input  logic                   send_btn_i,
    input  logic                   tx_busy_i,
    output logic [7:0]             tx_data_o,
    output logic                   tx_start_o,
    output logic [$clog2(DEPTH):0] fifo_count_o,
    output logic                   overflow_o,
    output logic [7:0]             last_byte_o
);

    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam int TW  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(ACK_TIMEOUT - 1);

    logic [1:0]     kb_sync_q;
    logic           kb_prev_q;
    logic [7:0]     last_make_q;
    logic [7:0]     last_make_d;
    logic [1:0]     btn_sync_q;
    logic           btn_last_q;
    logic           btn_stable_q;
    logic [DBW-1:0] db_cnt_q;
    logic           btn_pend_q;
    logic           btn_pend_d;
    tx_state_e      state_q;
    tx_state_e      state_d;
    logic [TW-1:0]  ack_cnt_q;
    logic [7:0]     tx_data_q;
    logic [7:0]     last_byte_q;
    logic           tx_start_q;
    logic           tx_start_d;
    logic           overflow_q;

    logic           key_event;
    logic           key_push;
    logic           btn_rise;
    logic           push;
    logic [7:0]     push_data;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_head;

    assign key_event = kb_sync_q[1] && !kb_prev_q;
    // The stable level is about to flip to 1 this cycle.
    assign btn_rise  = (btn_sync_q[1] == btn_last_q) && (db_cnt_q == DB_LAST)
                       && btn_last_q && !btn_stable_q;

    always_comb begin
        key_push    = 1'b0;
        last_make_d = last_make_q;
        if (key_event) begin
            if (kb_keycode_i[15:8] == KB_BREAK) begin
                last_make_d = '0;
            end else if (kb_keycode_i[7:0] != KB_BREAK && kb_keycode_i[7:0] != KB_EXT
                         && kb_char_i != 8'h00) begin
                key_push    = (REPEAT_EN != 0) || (kb_keycode_i[7:0] != last_make_q);
                last_make_d = kb_keycode_i[7:0];
            end
        end
    end

    // Key bytes win a same-cycle collision; the button byte follows one cycle later.
    always_comb begin
        push       = 1'b0;
        push_data  = 8'h00;
        btn_pend_d = btn_pend_q;
        if (key_push) begin
            push      = 1'b1;
            push_data = kb_char_i;
            if (btn_rise) begin
                btn_pend_d = 1'b1;
            end
        end else if (btn_pend_q || btn_rise) begin
            push       = 1'b1;
            push_data  = sw_data_i;
            btn_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            kb_sync_q    <= '0;
            kb_prev_q    <= 1'b0;
            last_make_q  <= '0;
            btn_sync_q   <= '0;
            btn_last_q   <= 1'b0;
            btn_stable_q <= 1'b0;
            db_cnt_q     <= '0;
            btn_pend_q   <= 1'b0;
        end else begin
            kb_sync_q   <= {kb_sync_q[0], kb_flag_i};
            kb_prev_q   <= kb_sync_q[1];
            last_make_q <= last_make_d;
            btn_sync_q  <= {btn_sync_q[0], send_btn_i};
            btn_pend_q  <= btn_pend_d;
            if (btn_sync_q[1] != btn_last_q) begin
                btn_last_q <= btn_sync_q[1];
                db_cnt_q   <= '0;
            end else if (db_cnt_q != DB_LAST) begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end else begin
                btn_stable_q <= btn_last_q;
            end
        end
    end

    key_tx_queue_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_o)
    );

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        tx_start_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !tx_busy_i) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    state_d    = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // A missing acknowledge still counts the byte as sent.
                if (tx_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (ack_cnt_q == TO_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            ack_cnt_q   <= '0;
            tx_data_q   <= '0;
            last_byte_q <= '0;
            tx_start_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            ack_cnt_q  <= (state_q == ST_WAIT_ACK) ? ack_cnt_q + 1'b1 : '0;
            if (pop) begin
                tx_data_q   <= fifo_head;
                last_byte_q <= fifo_head;
            end
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign tx_data_o   = tx_data_q;
    assign tx_start_o  = tx_start_q;
    assign overflow_o  = overflow_q;
    assign last_byte_o = last_byte_q;

endmodule

// File: tb/tb_key_tx_queue.sv
// Directed bench for key_tx_queue: scoreboard of expected transmitted bytes, a simple UART
// responder, and immediate-assertion checks of counts, flags and handshake timing.
module tb_key_tx_queue;

    localparam int DEPTH       = 4;
    localparam int DEBOUNCE    = 64;
    localparam int REPEAT_EN   = 0;
    localparam int ACK_TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        kb_flag;
    logic [15:0] kb_keycode;
    logic [7:0]  kb_char;
    logic [7:0]  sw_data;
    logic        send_btn;
    logic        tx_busy;
    logic [7:0]  tx_data_o;
    logic        tx_start_o;
    logic [2:0]  fifo_count_o;
    logic        overflow_o;
    logic [7:0]  last_byte_o;

    logic        force_busy;
    logic        uart_busy;
    logic        uart_en;
    logic [7:0]  sb[$];
    int          checks = 0;
    int          errors = 0;
    int          n_tx = 0;

    assign tx_busy = force_busy | uart_busy;

    always #5 clk = ~clk;

    key_tx_queue #(
        .DEPTH       (DEPTH),
        .DEBOUNCE    (DEBOUNCE),
        .REPEAT_EN   (REPEAT_EN),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .kb_flag_i    (kb_flag),
        .kb_keycode_i (kb_keycode),
        .kb_char_i    (kb_char),
        .sw_data_i    (sw_data),
        .send_btn_i   (send_btn),
        .tx_busy_i    (tx_busy),
        .tx_data_o    (tx_data_o),
        .tx_start_o   (tx_start_o),
        .fifo_count_o (fifo_count_o),
        .overflow_o   (overflow_o),
        .last_byte_o  (last_byte_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard consumer plus UART model: busy for 8 cycles after each accepted start.
    task automatic run_monitor();
        int         busy_cnt = 0;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (tx_start_o) begin
                n_tx++;
                $display("tx #%0d data=%02h last_byte=%02h count=%0d", n_tx, tx_data_o, last_byte_o, fifo_count_o);
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL tx_extra observed=%02h expected=none", tx_data_o);
                end
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    check("tx_data", {24'h0, tx_data_o}, {24'h0, exp_b});
                    check("last_byte_at_tx", {24'h0, last_byte_o}, {24'h0, exp_b});
                end
                if (uart_en) busy_cnt = 8;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            uart_busy = (busy_cnt != 0);
        end
    endtask

    task automatic key(input logic [15:0] code, input logic [7:0] ch, input bit expect_push);
        @(negedge clk);
        kb_keycode = code;
        kb_char    = ch;
        if (expect_push) sb.push_back(ch);
        kb_flag = 1'b1;
        repeat (3) @(negedge clk);
        kb_flag = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!(sb.size() == 0 && fifo_count_o == 0 && !tx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check(tag, {31'h0, n < 3000}, 32'h1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_data"}, {24'h0, tx_data_o}, 32'h0);
        check({tag, "_tx_start"}, {31'h0, tx_start_o}, 32'h0);
        check({tag, "_fifo_count"}, {29'h0, fifo_count_o}, 32'h0);
        check({tag, "_overflow"}, {31'h0, overflow_o}, 32'h0);
        check({tag, "_last_byte"}, {24'h0, last_byte_o}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int n;
        reset = 1'b1; kb_flag = 1'b0; kb_keycode = 16'h0; kb_char = 8'h0;
        sw_data = 8'h0; send_btn = 1'b0; force_busy = 1'b0; uart_busy = 1'b0; uart_en = 1'b1;
        fork
            run_monitor();
        join_none
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single key press: latency and transmitted byte.
        n0 = n_tx;
        kb_keycode = 16'h001C; kb_char = 8'h61;
        sb.push_back(8'h61);
        kb_flag = 1'b1;
        n = 0;
        while (!tx_start_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("key_to_start_latency", n, 4);
        kb_flag = 1'b0;
        drain("drain_single");
        check("single_last_byte", {24'h0, last_byte_o}, 32'h61);
        check("single_tx_count", n_tx - n0, 1);

        // Repeat suppression, break, prefix and unmapped codes.
        n0 = n_tx;
        key(16'hF01C, 8'h61, 1'b0);
        key(16'h001C, 8'h61, 1'b1);
        key(16'h001C, 8'h61, 1'b0);
        key(16'h001C, 8'h61, 1'b0);
        key(16'hF01C, 8'h61, 1'b0);
        key(16'h001C, 8'h61, 1'b1);
        key(16'h00E0, 8'h7A, 1'b0);
        key(16'h0076, 8'h00, 1'b0);
        drain("drain_repeat");
        check("repeat_tx_count", n_tx - n0, 2);

        // Bouncing button: short glitches ignored, one push on the stable rise, none on release.
        n0 = n_tx;
        sw_data = 8'hA5;
        for (int g = 0; g < 5; g++) begin
            send_btn = 1'b1;
            repeat (10) @(negedge clk);
            send_btn = 1'b0;
            repeat (90) @(negedge clk);
        end
        check("bounce_no_push", n_tx - n0, 0);
        sb.push_back(8'hA5);
        send_btn = 1'b1;
        repeat (DEBOUNCE + 20) @(negedge clk);
        drain("drain_button");
        send_btn = 1'b0;
        repeat (DEBOUNCE + 20) @(negedge clk);
        check("button_tx_count", n_tx - n0, 1);
        check("button_last_byte", {24'h0, last_byte_o}, 32'hA5);
        check("overflow_before_fill", {31'h0, overflow_o}, 32'h0);

        // Fill past DEPTH while the transmitter is busy.
        n0 = n_tx;
        force_busy = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            key({8'h00, 8'h15 + 8'(i)}, 8'h71 + 8'(i), i < DEPTH);
            if (i == DEPTH - 1) begin
                check("full_count", {29'h0, fifo_count_o}, DEPTH);
                check("full_no_overflow", {31'h0, overflow_o}, 32'h0);
            end
        end
        check("overflow_count", {29'h0, fifo_count_o}, DEPTH);
        check("overflow_flag", {31'h0, overflow_o}, 32'h1);
        force_busy = 1'b0;
        drain("drain_overflow");
        check("overflow_tx_count", n_tx - n0, DEPTH);
        check("overflow_sticky", {31'h0, overflow_o}, 32'h1);

        // Key event against button stable-rise, swept across the collision cycle.
        for (int t = 0; t < 3; t++) begin
            force_busy = 1'b1;
            @(negedge clk);
            sw_data = 8'hC1 + 8'(t);
            send_btn = 1'b1;
            sb.push_back(8'h62 + 8'(t));
            sb.push_back(8'hC1 + 8'(t));
            repeat (62 + t) @(negedge clk);
            kb_keycode = {8'h00, 8'h32 + 8'(t)};
            kb_char = 8'h62 + 8'(t);
            kb_flag = 1'b1;
            repeat (3) @(negedge clk);
            kb_flag = 1'b0;
            repeat (8) @(negedge clk);
            check("collide_count", {29'h0, fifo_count_o}, 32'h2);
            send_btn = 1'b0;
            repeat (DEBOUNCE + 10) @(negedge clk);
            force_busy = 1'b0;
            drain("drain_collide");
        end

        // No acknowledge: the FSM times out and launches the next byte.
        force_busy = 1'b1;
        uart_en = 1'b0;
        key(16'h0024, 8'h64, 1'b1);
        key(16'h002B, 8'h66, 1'b1);
        force_busy = 1'b0;
        n = 0;
        while (!tx_start_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_first_start", {31'h0, tx_start_o}, 32'h1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start_o && n < 200);
        check("ack_timeout_gap", n, ACK_TIMEOUT + 1);

        // Reset in the middle of a frame discards the queue.
        force_busy = 1'b1;
        key(16'h002C, 8'h67, 1'b0);
        check("queued_before_reset", {29'h0, fifo_count_o}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midframe_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        force_busy = 1'b0;
        uart_en = 1'b1;
        n0 = n_tx;
        repeat (60) @(negedge clk);
        check("no_start_after_reset", n_tx - n0, 0);
        key(16'h002D, 8'h68, 1'b1);
        drain("drain_after_reset");
        check("post_reset_tx_count", n_tx - n0, 1);
        check("post_reset_last_byte", {24'h0, last_byte_o}, 32'h68);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
